// File: rtl/csr_exec_unit.sv
// csr_exec_unit: executes Zicsr ops (CSRRW/S/C and immediate forms) as a
// read-modify-write against the downstream csr register file, one op at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a new op; decode and latch on accept
// S_RD_REQ | csr_read pulse to the csr file
// S_RD_CAP | csr read data returns; capture old value
// S_WR     | csr_write pulse with the merged write data
// S_RESP   | result held on out_* until the consumer takes it
module csr_exec_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_funct3,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [4:0]        in_rs1_field,
   input  logic [4:0]        in_rd_idx,
   output logic              csr_read,
   output logic              csr_write,
   output logic [ADDR_W-1:0] csr_addr,
   output logic [XLEN-1:0]   csr_write_data,
   input  logic [XLEN-1:0]   csr_read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_rd_idx,
   output logic [XLEN-1:0]   out_rd_data,
   output logic              out_rd_we,
   output logic              out_illegal
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_REQ = 3'd1,
      S_RD_CAP = 3'd2,
      S_WR     = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [XLEN-1:0]   r_operand;
   logic [4:0]        r_rd_idx;
   logic              r_do_read;
   logic              r_do_write;
   logic              r_illegal;
   logic [XLEN-1:0]   r_old;

   logic              w_is_rw;
   logic [XLEN-1:0]   w_operand;
   logic              w_do_read;
   logic              w_do_write;
   logic              w_illegal;
   logic [XLEN-1:0]   w_wdata;

   // funct3[1:0] selects RW/RS/RC; funct3[2] selects the zero-extended immediate.
   // Set/clear with a zero source never writes, so read-only CSRs stay legal for them.
   assign w_is_rw    = (in_funct3[1:0] == 2'b01);
   assign w_operand  = in_funct3[2] ? {{(XLEN-5){1'b0}}, in_rs1_field} : in_rs1_data;
   assign w_do_read  = !(w_is_rw && (in_rd_idx == 5'd0));
   assign w_do_write = w_is_rw || (in_rs1_field != 5'd0);
   assign w_illegal  = (in_funct3[1:0] == 2'b00) ||
                       (w_do_write && (in_addr[ADDR_W-1:ADDR_W-2] == 2'b11));

   // Merge operand into the old value; set/clear are pure bitwise ops.
   always_comb begin
      w_wdata = r_operand;
      case (r_op)
         2'b10:   w_wdata = r_old | r_operand;
         2'b11:   w_wdata = r_old & ~r_operand;
         default: w_wdata = r_operand;
      endcase
   end

   // State register; async reset drops any op in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state and Moore outputs; strobes and results are driven only in their own state.
   always_comb begin
      w_state_nxt    = r_state;
      in_ready       = 1'b0;
      csr_read       = 1'b0;
      csr_write      = 1'b0;
      csr_addr       = '0;
      csr_write_data = '0;
      out_valid      = 1'b0;
      out_rd_idx     = 5'd0;
      out_rd_data    = '0;
      out_rd_we      = 1'b0;
      out_illegal    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (w_illegal)      w_state_nxt = S_RESP;
               else if (w_do_read) w_state_nxt = S_RD_REQ;
               else                w_state_nxt = S_WR;
            end
         end
         S_RD_REQ: begin
            csr_read    = 1'b1;
            csr_addr    = r_addr;
            w_state_nxt = S_RD_CAP;
         end
         S_RD_CAP: begin
            w_state_nxt = r_do_write ? S_WR : S_RESP;
         end
         S_WR: begin
            csr_write      = 1'b1;
            csr_addr       = r_addr;
            csr_write_data = w_wdata;
            w_state_nxt    = S_RESP;
         end
         S_RESP: begin
            out_valid   = 1'b1;
            out_rd_idx  = r_rd_idx;
            out_rd_data = r_old;
            out_rd_we   = r_do_read && !r_illegal && (r_rd_idx != 5'd0);
            out_illegal = r_illegal;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Latch the decoded op on accept and capture the old CSR value in RD_CAP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op       <= 2'b00;
         r_addr     <= '0;
         r_operand  <= '0;
         r_rd_idx   <= 5'd0;
         r_do_read  <= 1'b0;
         r_do_write <= 1'b0;
         r_illegal  <= 1'b0;
         r_old      <= '0;
      end else if (r_state == S_IDLE && in_valid) begin
         r_op       <= in_funct3[1:0];
         r_addr     <= in_addr;
         r_operand  <= w_operand;
         r_rd_idx   <= in_rd_idx;
         r_do_read  <= w_do_read;
         r_do_write <= w_do_write;
         r_illegal  <= w_illegal;
         r_old      <= '0;
      end else if (r_state == S_RD_CAP) begin
         r_old      <= csr_read_data;
      end
   end

endmodule

// File: tb/tb_csr_exec_unit.sv
// tb_csr_exec_unit: directed Zicsr cases plus random ops against an array-based
// model of the csr file and the instruction rules.
module tb_csr_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_funct3 = 3'd0;
   logic [11:0] in_addr = 12'd0;
   logic [31:0] in_rs1_data = 32'd0;
   logic [4:0]  in_rs1_field = 5'd0;
   logic [4:0]  in_rd_idx = 5'd0;
   logic        csr_read;
   logic        csr_write;
   logic [11:0] csr_addr;
   logic [31:0] csr_write_data;
   logic [31:0] csr_read_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_rd_idx;
   logic [31:0] out_rd_data;
   logic        out_rd_we;
   logic        out_illegal;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] csr_mem [0:4095];
   logic [31:0] ref_mem [0:4095];
   int          n_rd = 0;
   int          n_wr = 0;
   logic [11:0] last_wr_addr = 12'd0;
   logic [31:0] last_wr_data = 32'd0;
   logic        prev_rd = 1'b0;
   logic        prev_wr = 1'b0;

   csr_exec_unit #(.XLEN(32), .ADDR_W(12)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
      .in_addr(in_addr), .in_rs1_data(in_rs1_data), .in_rs1_field(in_rs1_field),
      .in_rd_idx(in_rd_idx),
      .csr_read(csr_read), .csr_write(csr_write), .csr_addr(csr_addr),
      .csr_write_data(csr_write_data), .csr_read_data(csr_read_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd_idx(out_rd_idx),
      .out_rd_data(out_rd_data), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // csr file model: read data valid only the cycle after csr_read, junk otherwise
   always @(posedge clk) begin
      if (rst) begin
         if (csr_read || csr_write) begin
            check("strobe_excl", {31'd0, csr_read & csr_write}, 32'd0);
            check("rd_pulse", {31'd0, csr_read & prev_rd}, 32'd0);
            check("wr_pulse", {31'd0, csr_write & prev_wr}, 32'd0);
         end
         if (csr_read) begin
            n_rd++;
            csr_read_data <= csr_mem[csr_addr];
         end else begin
            csr_read_data <= $urandom;
         end
         if (csr_write) begin
            n_wr++;
            csr_mem[csr_addr] = csr_write_data;
            last_wr_addr = csr_addr;
            last_wr_data = csr_write_data;
         end
      end
      prev_rd = csr_read;
      prev_wr = csr_write;
   end

   task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                         input logic [4:0] fld, input logic [4:0] rd, input int hold);
      logic        is_rw, dr, dw, ill, exp_rd, exp_wr;
      logic [31:0] opnd, old, newv, held;
      int          lat, cyc, rd0, wr0;
      is_rw  = (f3 == 3'b001) || (f3 == 3'b101);
      opnd   = f3[2] ? {27'd0, fld} : rs1;
      dr     = !(is_rw && rd == 5'd0);
      dw     = is_rw || (fld != 5'd0);
      ill    = (f3 == 3'b000) || (f3 == 3'b100) || (dw && a >= 12'hC00);
      exp_rd = !ill && dr;
      exp_wr = !ill && dw;
      old    = exp_rd ? ref_mem[a] : 32'd0;
      if (f3 == 3'b010 || f3 == 3'b110)      newv = old | opnd;
      else if (f3 == 3'b011 || f3 == 3'b111) newv = old & ~opnd;
      else                                   newv = opnd;
      if (ill)                lat = 1;
      else if (exp_rd && exp_wr) lat = 4;
      else if (exp_rd)        lat = 3;
      else                    lat = 2;
      if (exp_wr) ref_mem[a] = newv;
      rd0 = n_rd;
      wr0 = n_wr;

      @(negedge clk);
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_funct3 = f3; in_addr = a; in_rs1_data = rs1; in_rs1_field = fld; in_rd_idx = rd;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_funct3 = 3'($urandom); in_addr = 12'($urandom); in_rs1_data = $urandom;
      in_rs1_field = 5'($urandom); in_rd_idx = 5'($urandom);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 20);
      check("latency", cyc, lat);
      check("rd_idx", {27'd0, out_rd_idx}, {27'd0, rd});
      check("rd_data", out_rd_data, old);
      check("rd_we", {31'd0, out_rd_we}, {31'd0, exp_rd && rd != 5'd0});
      check("illegal", {31'd0, out_illegal}, {31'd0, ill});
      check("n_reads", n_rd - rd0, {31'd0, exp_rd});
      check("n_writes", n_wr - wr0, {31'd0, exp_wr});
      if (exp_wr) begin
         check("wr_addr", {20'd0, last_wr_addr}, {20'd0, a});
         check("wr_data", last_wr_data, newv);
      end
      held = out_rd_data;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; in_funct3 = 3'b001; in_addr = 12'h340; in_rd_idx = 5'd1;
         out_ready = 1'b0;
         @(negedge clk);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_data", out_rd_data, held);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("no_extra_rd", n_rd - rd0, {31'd0, exp_rd});
      check("no_extra_wr", n_wr - wr0, {31'd0, exp_wr});
      @(negedge clk);
      check("back_idle", {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         csr_mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      csr_mem[12'h341] = 32'h12345678;
      ref_mem[12'h341] = 32'h12345678;

      #3;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_outs", {28'd0, out_valid, out_rd_we, out_illegal, csr_read | csr_write}, 32'd0);
      check("rst_rd_data", out_rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // reset in the middle of the write cycle abandons the op
      @(negedge clk);
      in_funct3 = 3'b001; in_addr = 12'h300; in_rs1_data = 32'hAAAA5555;
      in_rs1_field = 5'd1; in_rd_idx = 5'd1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int c = 0; c < 10 && !csr_write; c++) @(negedge clk);
      check("saw_csr_write", {31'd0, csr_write}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_csr_write", {31'd0, csr_write}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_outs", {28'd0, out_valid, out_rd_we, out_illegal, csr_read}, 32'd0);
      check("arst_wdata", csr_write_data, 32'd0);
      check("arst_addr", {20'd0, csr_addr}, 32'd0);
      @(negedge clk);
      check("arst_no_write", n_wr, 32'd0);
      check("arst_mem", csr_mem[12'h300], 32'd0);
      rst = 1'b1;

      run_op(3'b001, 12'h300, 32'hDEADBEEF, 5'd1, 5'd5, 0);
      run_op(3'b010, 12'h300, 32'h000000F0, 5'd2, 5'd6, 0);
      run_op(3'b011, 12'h300, 32'h000000F0, 5'd2, 5'd6, 0);
      check("mem_after_rc", csr_mem[12'h300], 32'hDEADBE0F);
      run_op(3'b110, 12'h341, 32'hFFFFFFFF, 5'd0, 5'd7, 0);
      run_op(3'b101, 12'h341, 32'h0, 5'h1F, 5'd0, 0);
      check("mem_after_rwi", csr_mem[12'h341], 32'h0000001F);
      run_op(3'b001, 12'hC00, 32'h11111111, 5'd3, 5'd3, 0);
      run_op(3'b100, 12'h300, 32'h22222222, 5'd3, 5'd4, 0);
      run_op(3'b010, 12'hC00, 32'h0, 5'd0, 5'd8, 0);
      run_op(3'b011, 12'h300, 32'h0000FFFF, 5'd9, 5'd9, 5);

      for (int k = 0; k < 150; k++) begin
         logic [11:0] a;
         logic [4:0]  fld, rd;
         case ($urandom_range(0, 4))
            0: a = 12'h300;
            1: a = 12'h341;
            2: a = 12'hC00 | 12'($urandom_range(0, 3));
            3: a = 12'h305;
            default: a = 12'($urandom);
         endcase
         fld = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         run_op(3'($urandom), a, $urandom, fld, rd, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
